// File: rtl/gas_pkg.sv
// rtl/gas_pkg.sv - shared constants, state codes and level classification for the gas alarm controller
package gas_pkg;

    localparam int LEVEL_W = 3;

    typedef enum logic [1:0] {
        SAFE  = 2'd0,
        WARN  = 2'd1,
        ALARM = 2'd2,
        LATCH = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_WARN  = 2'd1,
        CLS_ALARM = 2'd2
    } class_e;

    function automatic class_e classify(input logic [LEVEL_W-1:0] lvl,
                                        input int warn_th,
                                        input int alarm_th);
        if (int'(lvl) >= alarm_th)     return CLS_ALARM;
        else if (int'(lvl) >= warn_th) return CLS_WARN;
        else                           return CLS_NONE;
    endfunction

endpackage

// File: rtl/gas_persist_counter.sv
// rtl/gas_persist_counter.sv - saturating consecutive-cycle counter; hit marks the LIMIT-th qualifying cycle
module gas_persist_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic arst,
    input  logic qualify,
    input  logic clr,
    output logic hit
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !qualify) begin
            cnt_d = '0;
        end else if (cnt_q != LIM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Combinational so the owner can transition on the edge that closes the qualifying cycle.
    assign hit = qualify && (cnt_q >= (LIM - 1'b1));

    always_ff @(posedge clk) begin
        if (arst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gas_alarm_controller.sv
// rtl/gas_alarm_controller.sv - gas alarm FSM with persistence filtering, buzzer and peak hold
module gas_alarm_controller
    import gas_pkg::*;
#(
    parameter int WARN_TH   = 3,
    parameter int ALARM_TH  = 6,
    parameter int CONFIRM   = 4,
    parameter int CLEAR     = 8,
    parameter int BEEP_LOG2 = 3
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [LEVEL_W-1:0] level,
    input  logic               ack,
    output logic [1:0]         state,
    output logic               alarm,
    output logic               fan_on,
    output logic               buzzer,
    output logic [LEVEL_W-1:0] peak
);

    state_e               state_q, state_d;
    class_e               cls;
    logic                 up_qual, dn_qual, up_hit, dn_hit, state_chg;
    logic [BEEP_LOG2:0]   beep_q, beep_d;
    logic [LEVEL_W-1:0]   peak_q, peak_d;
    logic                 alarm_q, fan_q;

    assign cls       = classify(level, WARN_TH, ALARM_TH);
    assign state_chg = (state_d != state_q);

    gas_persist_counter #(.LIMIT(CONFIRM)) u_up_cnt (
        .clk(clk), .arst(arst), .qualify(up_qual), .clr(state_chg), .hit(up_hit)
    );

    gas_persist_counter #(.LIMIT(CLEAR)) u_dn_cnt (
        .clk(clk), .arst(arst), .qualify(dn_qual), .clr(state_chg), .hit(dn_hit)
    );

    always_comb begin
        up_qual = 1'b0;
        dn_qual = 1'b0;
        state_d = state_q;
        case (state_q)
            SAFE: begin
                up_qual = (cls != CLS_NONE);
                if (up_hit) state_d = (cls == CLS_ALARM) ? ALARM : WARN;
            end
            WARN: begin
                up_qual = (cls == CLS_ALARM);
                dn_qual = (cls == CLS_NONE);
                if (up_hit)      state_d = ALARM;
                else if (dn_hit) state_d = SAFE;
            end
            ALARM: begin
                dn_qual = (cls == CLS_NONE);
                if (dn_hit) state_d = LATCH;
            end
            LATCH: begin
                // A re-trip outranks an acknowledge arriving in the same cycle.
                up_qual = (cls != CLS_NONE);
                if (up_hit)   state_d = ALARM;
                else if (ack) state_d = SAFE;
            end
            default: state_d = SAFE;
        endcase

        beep_d = '0;
        if (state_d == ALARM && state_q == ALARM) beep_d = beep_q + 1'b1;

        if (state_q == LATCH && state_d == SAFE) peak_d = '0;
        else                                     peak_d = (level > peak_q) ? level : peak_q;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= SAFE;
            beep_q  <= '0;
            peak_q  <= '0;
            alarm_q <= 1'b0;
            fan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beep_q  <= beep_d;
            peak_q  <= peak_d;
            alarm_q <= (state_d == ALARM) || (state_d == LATCH);
            fan_q   <= (state_d != SAFE);
        end
    end

    // beep_q is held at zero outside ALARM, so its MSB alone gates the buzzer.
    assign state  = state_q;
    assign alarm  = alarm_q;
    assign fan_on = fan_q;
    assign buzzer = beep_q[BEEP_LOG2];
    assign peak   = peak_q;

endmodule
